// File: rtl/mio_arbiter.sv
// mio_arbiter
//   Two-port arbiter (CPU controller, DMA requester) for the single shared
//   memory/IO bus. A granted request becomes one bus access of
//   WAIT_CYCLES+1 cycles. A one-cycle completion pulse follows on the
//   owner's side: MIO_ready for the CPU, dma_ack for the DMA.
//
// Parameters
//   WAIT_CYCLES  extra bus cycles before mem_rdata is valid (0..15)
//
// Configuration macro
//   MIO_ARB_RR_EN  defined: round-robin on simultaneous requests.
//                  undefined: fixed priority, the CPU wins ties.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request (level, held until MIO_ready)
//   cpu_rdata, MIO_ready           CPU read data (registered), completion pulse
//   dma_req/we/addr/wdata          DMA request (level, held until dma_ack)
//   dma_rdata, dma_ack             DMA read data (registered), completion pulse
//   mem_en, mem_we                 bus access active, bus write strobe
//   mem_addr, mem_wdata            bus address / write data (held between accesses)
//   mem_rdata                      bus read data
module mio_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        MIO_ready,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t     state, state_nxt;
    owner_t     owner, last_owner, grant;
    logic [3:0] wait_cnt;
    logic       bus_we;
    logic       any_req;

    assign any_req = cpu_req | dma_req;

    // Grant decision, only consumed in IDLE.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = OWN_CPU;
`ifdef MIO_ARB_RR_EN
        // On a tie, the port that did not own the previous access wins.
        if (cpu_req && dma_req)
            grant = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        else if (dma_req)
            grant = OWN_DMA;
`else
        if (!cpu_req && dma_req)
            grant = OWN_DMA;
`endif
    end

    // Next state and bus/handshake outputs, decoded from the current state.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        MIO_ready = 1'b0;
        dma_ack   = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req)
                    state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                mem_en = 1'b1;
                mem_we = bus_we;
                if (wait_cnt == 4'd0)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                MIO_ready = (owner == OWN_CPU);
                dma_ack   = (owner == OWN_DMA);
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DMA;
            wait_cnt   <= 4'd0;
            bus_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            cpu_rdata  <= 32'd0;
            dma_rdata  <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner    <= grant;
                        wait_cnt <= WAIT_LOAD;
                        if (grant == OWN_DMA) begin
                            bus_we    <= dma_we;
                            mem_addr  <= dma_addr;
                            mem_wdata <= dma_wdata;
                        end else begin
                            bus_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        // Final access cycle: read data is valid now.
                        if (!bus_we) begin
                            if (owner == OWN_CPU)
                                cpu_rdata <= mem_rdata;
                            else
                                dma_rdata <= mem_rdata;
                        end
                        last_owner <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_arbiter.sv
module tb_mio_arbiter;

    localparam int W = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        bit          owner;   // 0 = CPU, 1 = DMA
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          t_req;   // cycle the request went up, -1 = no latency check
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        MIO_ready, dma_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // Second instance with zero wait states, CPU side only.
    logic        cpu_req0;
    logic [31:0] cpu_addr0, cpu_rdata0, dma_rdata0;
    logic        mio_ready0, dma_ack0, mem_en0, mem_we0;
    logic [31:0] mem_addr0, mem_wdata0, mem_rdata0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   en_run = 0;
    bit   seen [2];
    exp_t sb [$];
    exp_t mon_e;
    logic [31:0] cpu_model, dma_model;

    always #5 clk = ~clk;

    mio_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mio_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req0), .cpu_we(1'b0), .cpu_addr(cpu_addr0), .cpu_wdata(32'h0),
        .cpu_rdata(cpu_rdata0), .MIO_ready(mio_ready0),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(dma_rdata0), .dma_ack(dma_ack0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
    endfunction

    // Memory model: data valid only in the last cycle of a bus access.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        en_cnt <= mem_en ? en_cnt + 1 : 0;
    end
    assign mem_rdata  = (mem_en && en_cnt == W) ? mem_fn(mem_addr) : 32'hBAD0_BAD0;
    assign mem_rdata0 = mem_en0 ? mem_fn(mem_addr0) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            cpu_model = 32'd0;
            dma_model = 32'd0;
            en_run    = 0;
        end else begin
            if (MIO_ready && dma_ack) check("dual_pulse", 1, 0);
            if (mem_we && !mem_en)    check("we_without_en", 1, 0);
            if (mem_en) begin
                en_run++;
                if (sb.size() > 0) begin
                    check("bus_addr", mem_addr, sb[0].addr);
                    check("bus_wdata", mem_wdata, sb[0].wdata);
                    check("bus_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                end
            end else if (MIO_ready || dma_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_owner", {31'd0, dma_ack}, {31'd0, mon_e.owner});
                    check("en_cycles", en_run, W + 1);
                    if (mon_e.t_req >= 0) check("latency", cyc - mon_e.t_req, W + 2);
                    if (!mon_e.we) begin
                        if (mon_e.owner) dma_model = mem_fn(mon_e.addr);
                        else             cpu_model = mem_fn(mon_e.addr);
                    end
                    check("cpu_rdata", cpu_rdata, cpu_model);
                    check("dma_rdata", dma_rdata, dma_model);
                    seen[mon_e.owner] = 1'b1;
                end
                en_run = 0;
            end else begin
                en_run = 0;
            end
        end
    end

    task automatic set_port(input bit port, input logic req, input req_t r);
        if (port == 1'b0) begin
            cpu_req = req; cpu_we = r.we; cpu_addr = r.addr; cpu_wdata = r.wdata;
        end else begin
            dma_req = req; dma_we = r.we; dma_addr = r.addr; dma_wdata = r.wdata;
        end
    endtask

    task automatic push_exp(input bit port, input req_t r, input int t);
        exp_t e;
        e.owner = port; e.we = r.we; e.addr = r.addr; e.wdata = r.wdata; e.t_req = t;
        sb.push_back(e);
    endtask

    // Requester: holds the request through n pulses, switching to r1 after
    // the first one; drops it on the edge that ends the last pulse.
    task automatic run_port(input bit port, input int n, input req_t r0, input req_t r1);
        int k;
        set_port(port, 1'b1, r0);
        for (int i = 0; i < n; i++) begin
            seen[port] = 1'b0;
            k = 0;
            while (!seen[port] && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            check(port ? "dma_done" : "cpu_done", {31'd0, seen[port]}, 1);
            seen[port] = 1'b0;
            set_port(port, (i + 1 < n), r1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1 check(tag, sb.size(), 0);
    endtask

    initial begin
        req_t rc, rd, ca, cb;
        int   t0, en0, pc;
        bit   got;

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        cpu_req0 = 0; cpu_addr0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", {31'd0, mem_en}, 0);
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        check("rst_pulses", {30'd0, MIO_ready, dma_ack}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Lone CPU read.
        rc = '{we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0};
        t0 = cyc;
        push_exp(1'b0, rc, t0);
        run_port(1'b0, 1, rc, rc);
        drain("sb_cpu_read");
        check("cpu_read_data", cpu_rdata, 32'hDEADBEEF);

        // Lone DMA write.
        rd = '{we: 1'b1, addr: 32'h0000_0100, wdata: 32'h1234_5678};
        t0 = cyc;
        push_exp(1'b1, rd, t0);
        run_port(1'b1, 1, rd, rd);
        drain("sb_dma_write");
        check("dma_rdata_kept", dma_rdata, 0);

        // Both requests from reset: CPU first in either configuration.
        do_reset();
        rc = '{we: 1'b0, addr: 32'h0000_0020, wdata: 32'h1111_1111};
        rd = '{we: 1'b0, addr: 32'h0000_0200, wdata: 32'h2222_2222};
        t0 = cyc;
        push_exp(1'b0, rc, t0);
        push_exp(1'b1, rd, -1);
        fork
            run_port(1'b0, 1, rc, rc);
            run_port(1'b1, 1, rd, rd);
        join
        drain("sb_tie");

        // Back-to-back CPU requests with DMA held.
        ca = '{we: 1'b0, addr: 32'h0000_0030, wdata: 32'h3333_3333};
        cb = '{we: 1'b1, addr: 32'h0000_0034, wdata: 32'h4444_4444};
        rd = '{we: 1'b0, addr: 32'h0000_0300, wdata: 32'h5555_5555};
        t0 = cyc;
        push_exp(1'b0, ca, t0);
`ifdef MIO_ARB_RR_EN
        push_exp(1'b1, rd, -1);
        push_exp(1'b0, cb, -1);
`else
        push_exp(1'b0, cb, -1);
        push_exp(1'b1, rd, -1);
`endif
        fork
            run_port(1'b0, 2, ca, cb);
            run_port(1'b1, 1, rd, rd);
        join
        drain("sb_b2b");

        // Reset during the second ACCESS cycle of a CPU read.
        rc = '{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0};
        set_port(1'b0, 1'b1, rc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_mem_en", {31'd0, mem_en}, 0);
        check("abort_pulse", {31'd0, MIO_ready}, 0);
        check("abort_cpu_rdata", cpu_rdata, 0);
        drain("sb_abort");

        // Zero wait states on the second instance.
        @(posedge clk); #1;
        t0 = cyc;
        cpu_req0 = 1'b1;
        cpu_addr0 = 32'h0000_0044;
        en0 = 0; got = 0; pc = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mem_en0) en0++;
            if (mio_ready0) begin got = 1; pc = cyc; end
        end
        @(posedge clk); #1 cpu_req0 = 1'b0;
        check("w0_pulse", {31'd0, got}, 1);
        check("w0_en_cycles", en0, 1);
        check("w0_latency", pc - t0, 2);
        check("w0_rdata", cpu_rdata0, mem_fn(32'h0000_0044));
        check("w0_dma_ack", {31'd0, dma_ack0}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Two-port arbiter between the multicycle CPU controller and a DMA requester for the single shared memory/IO bus. Converts the CPU's level request into a sequenced bus access with a fixed wait-state count and returns the `MIO_ready` completion pulse that the controller's fetch and memory states poll. Sits between the CPU datapath/controller, the DMA engine and the RAM/IO decoder.

## Interface
- `WAIT_CYCLES`, default 2: extra bus cycles the memory needs before `mem_rdata` is valid (0..15).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU bus request (driven from `CPU_MIO`), level, held until `MIO_ready`.
- `cpu_we`  in  1  CPU write (from `MemWrite`).
- `cpu_addr`  in  32  CPU byte address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_rdata`  out  32  CPU read data, registered.
- `MIO_ready`  out  1  one-cycle CPU completion pulse.
- `dma_req`  in  1  DMA request, level, held until `dma_ack`.
- `dma_we`  in  1  DMA write.
- `dma_addr`  in  32  DMA byte address.
- `dma_wdata`  in  32  DMA write data.
- `dma_rdata`  out  32  DMA read data, registered.
- `dma_ack`  out  1  one-cycle DMA completion pulse.
- `mem_en`  out  1  bus access active.
- `mem_we`  out  1  bus write strobe.
- `mem_addr`  out  32  bus address.
- `mem_wdata`  out  32  bus write data.
- `mem_rdata`  in  32  bus read data.

## Operation
- States: IDLE, ACCESS, DONE. Registers: `owner` (CPU/DMA), `last_owner`, 4-bit `wait_cnt`.
- IDLE: outputs quiescent (`mem_en`=0, `mem_we`=0). If any request is present, pick owner, latch owner's `we`/`addr`/`wdata` into bus registers, load `wait_cnt`=`WAIT_CYCLES`, go ACCESS. Without a request, stay in IDLE.
- ACCESS: `mem_en`=1, `mem_we`=latched we, address/data held from latch. If `wait_cnt`≠0, decrement and stay. If `wait_cnt`=0, capture `mem_rdata` into the owner's rdata register (reads only; writes leave rdata unchanged), set `last_owner`=owner, go DONE.
- DONE: `mem_en`=0, `mem_we`=0. Pulse `MIO_ready` (owner CPU) or `dma_ack` (owner DMA) for exactly this cycle. Go IDLE unconditionally.
- Requester contract: the requester deasserts its request on the edge on which it sees its pulse. A request still high in IDLE is treated as a new access.
- Requests arriving during ACCESS/DONE wait. They are not dropped.
- Non-owner `rdata` holds its previous value. The non-owner never sees a pulse.
- `mem_addr`/`mem_wdata` hold their last latched values in IDLE/DONE.

## Timing
- Reset (synchronous, takes priority over all transitions, aborts any access mid-flight with no pulse): state=IDLE, `MIO_ready`=0, `dma_ack`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0, `dma_rdata`=0, `wait_cnt`=0, `last_owner`=DMA.
- Latency: request sampled in IDLE at edge N. ACCESS occupies cycles N+1..N+1+`WAIT_CYCLES`. The pulse is high in cycle N+2+`WAIT_CYCLES`. With `WAIT_CYCLES`=2, a request seen at edge 0 gives a pulse in cycle 4.
- Throughput: one access per `WAIT_CYCLES`+3 cycles. IDLE is always visited between accesses.
- `WAIT_CYCLES`=0: ACCESS lasts one cycle and `mem_rdata` is captured at its end.

## Configuration
- `MIO_ARB_RR_EN` defined: round-robin on simultaneous requests in IDLE. Grant goes to the port that is not `last_owner`. A single requester is always granted.
- Not defined: fixed priority, CPU always wins ties. `last_owner` is still maintained but unused.

## Test plan
- Reset then lone CPU read, addr 0x0000_0010, `mem_rdata`=0xDEADBEEF, `WAIT_CYCLES`=2 -> `mem_en` high 3 cycles, `cpu_rdata`=0xDEADBEEF, `MIO_ready` one pulse 4 cycles after request; `dma_ack` stays 0.
- Lone DMA write, addr 0x100, data 0x12345678 -> `mem_we`=1 for 3 cycles with addr/data stable; `dma_ack` pulses once; `dma_rdata` unchanged.
- Both requests asserted together from reset, held through two accesses, RR enabled -> CPU served first (`last_owner`=DMA at reset), then DMA. With the macro off, the first grant is still CPU.
- Back-to-back CPU requests with DMA held continuously, RR enabled -> grants alternate CPU, DMA, CPU. With the macro off, the CPU request wins every tie.
- Assert `reset` during the second ACCESS cycle of a CPU read -> next cycle state IDLE, `mem_en`=0, no `MIO_ready` pulse, `cpu_rdata`=0.
- `WAIT_CYCLES`=0, CPU read -> `mem_en` high exactly 1 cycle, `MIO_ready` in cycle 2 after request.
